// File: rtl/ibex_csr_access_ctrl.sv
// Shares a bank of NumCsr CSR primitives between the core CSR unit (0) and debug (1),
// running each access as grant -> execute -> response. Define CSR_CTRL_RO_EN to honour ReadOnlyMask.
module ibex_csr_access_ctrl #(
  parameter int                NumCsr       = 8,
  parameter int                AddrWidth    = 3,
  parameter logic [NumCsr-1:0] ReadOnlyMask = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [1:0]             req_i,
  input  logic [3:0]             op_i,
  input  logic [2*AddrWidth-1:0] addr_i,
  input  logic [63:0]            wdata_i,
  output logic [1:0]             gnt_o,
  output logic [1:0]             rvalid_o,
  output logic [31:0]            rdata_o,
  output logic                   err_o,
  output logic [NumCsr-1:0]      csr_wr_en_o,
  output logic [31:0]            csr_wr_data_o,
  input  logic [32*NumCsr-1:0]   csr_rd_data_i,
  input  logic [NumCsr-1:0]      csr_rd_error_i
);

  // Handshake: a requester raises req_i with op/addr/wdata stable and holds them until it
  // sees gnt_o (one cycle, IDLE only); rvalid_o[owner] pulses exactly two cycles after gnt_o.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpSet   = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic [1:0]             op_q, op_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   prio_q, prio_d;
  logic [1:0]             rvalid_q, rvalid_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic                   winner;
  logic [31:0]            old_val;
  logic [31:0]            new_val;
  logic                   old_err;
  logic                   in_range;
  logic                   ro_hit;
  logic                   do_write;

  // prio_q names the requester that wins a tie; it flips to the loser on every grant.
  assign winner = (req_i == 2'b11) ? prio_q : req_i[1];
  assign gnt_o  = (rst_ni && (state_q == IDLE) && (|req_i)) ? (winner ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    old_val  = '0;
    old_err  = 1'b0;
    in_range = 1'b0;
    for (int k = 0; k < NumCsr; k++) begin
      if (addr_q == AddrWidth'(k)) begin
        old_val  = csr_rd_data_i[32*k +: 32];
        old_err  = csr_rd_error_i[k];
        in_range = 1'b1;
      end
    end
  end

`ifdef CSR_CTRL_RO_EN
  always_comb begin
    ro_hit = 1'b0;
    for (int k = 0; k < NumCsr; k++) begin
      if (addr_q == AddrWidth'(k)) begin
        ro_hit = ReadOnlyMask[k] && (op_q != OpRead);
      end
    end
  end
`else
  logic unused_ro_mask;
  assign unused_ro_mask = ^ReadOnlyMask;
  assign ro_hit         = 1'b0;
`endif

  always_comb begin
    unique case (op_q)
      OpWrite: new_val = wdata_q;
      OpSet:   new_val = old_val | wdata_q;
      OpClear: new_val = old_val & ~wdata_q;
      default: new_val = old_val;
    endcase
  end

  assign do_write = (state_q == EXEC) && (op_q != OpRead) && in_range && !ro_hit;

  always_comb begin
    csr_wr_en_o = '0;
    for (int k = 0; k < NumCsr; k++) begin
      csr_wr_en_o[k] = do_write && (addr_q == AddrWidth'(k));
    end
  end

  assign csr_wr_data_o = do_write ? new_val : 32'h0;

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    prio_d   = prio_q;
    rvalid_d = 2'b00;
    rdata_d  = 32'h0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = EXEC;
          owner_d = winner;
          op_d    = winner ? op_i[3:2] : op_i[1:0];
          addr_d  = winner ? addr_i[2*AddrWidth-1:AddrWidth] : addr_i[AddrWidth-1:0];
          wdata_d = winner ? wdata_i[63:32] : wdata_i[31:0];
          prio_d  = ~winner;
        end
      end
      EXEC: begin
        // Response carries the pre-write value; out-of-range reads return zero.
        state_d  = RESP;
        rvalid_d = owner_q ? 2'b10 : 2'b01;
        rdata_d  = old_val;
        err_d    = !in_range || ro_hit || old_err;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      op_q     <= OpRead;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      prio_q   <= 1'b0;
      rvalid_q <= 2'b00;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      prio_q   <= prio_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_ibex_csr_access_ctrl.sv
// Bench for ibex_csr_access_ctrl: directed vector table, reset/alternation sequences,
// then random traffic checked against a transaction-level reference model.
module tb_ibex_csr_access_ctrl;
  localparam int NumCsr    = 6;
  localparam int AddrWidth = 3;
  localparam logic [NumCsr-1:0] RoMask = 6'h01;
`ifdef CSR_CTRL_RO_EN
  localparam bit RoEn = 1'b1;
`else
  localparam bit RoEn = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [1:0]             req = 2'b00;
  logic [3:0]             op = 4'h0;
  logic [2*AddrWidth-1:0] addr = '0;
  logic [63:0]            wdata = 64'h0;
  logic [1:0]             gnt, rvalid;
  logic [31:0]            rdata;
  logic                   err;
  logic [NumCsr-1:0]      csr_wr_en;
  logic [31:0]            csr_wr_data;
  logic [32*NumCsr-1:0]   csr_rd_data;
  logic [NumCsr-1:0]      rd_err = '0;
  logic [31:0]            csr_mem [NumCsr];

  int checks = 0;
  int failures = 0;

  ibex_csr_access_ctrl #(.NumCsr(NumCsr), .AddrWidth(AddrWidth), .ReadOnlyMask(RoMask)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .op_i(op), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .csr_wr_en_o(csr_wr_en), .csr_wr_data_o(csr_wr_data),
    .csr_rd_data_i(csr_rd_data), .csr_rd_error_i(rd_err)
  );

  always #5 clk = ~clk;

  // CSR primitive bank seen by the DUT
  always_comb begin
    for (int k = 0; k < NumCsr; k++) csr_rd_data[32*k +: 32] = csr_mem[k];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NumCsr; k++) csr_mem[k] <= 32'h0;
    end else begin
      for (int k = 0; k < NumCsr; k++) if (csr_wr_en[k]) csr_mem[k] <= csr_wr_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_port(input int id, input logic [1:0] o, input logic [2:0] a, input logic [31:0] d);
    if (id == 0) begin
      op[1:0] = o; addr[2:0] = a; wdata[31:0] = d;
    end else begin
      op[3:2] = o; addr[5:3] = a; wdata[63:32] = d;
    end
  endtask

  function automatic logic [31:0] apply_op(input logic [1:0] o, input logic [31:0] old, input logic [31:0] d);
    case (o)
      2'b01:   return d;
      2'b10:   return old | d;
      2'b11:   return old & ~d;
      default: return old;
    endcase
  endfunction

  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [5:0]  rderr;
    logic [5:0]  e_wen;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    logic        e_err;
  } vec_t;

  vec_t vecs[13];
  vec_t v;

  // reference model state for the random phase
  logic [31:0] m_mem [NumCsr];
  int          free_at;
  bit          acc_v, acc_own, acc_err, last_own, w;
  int          acc_g;
  logic [1:0]  acc_op;
  logic [2:0]  acc_addr;
  logic [31:0] acc_wd, acc_rd;
  bit          h_v [2];
  logic [1:0]  h_op [2];
  logic [2:0]  h_addr [2];
  logic [31:0] h_wd [2];
  logic [1:0]  e_gnt, e_rv;
  logic [5:0]  e_wen;
  logic [31:0] e_wd, e_rd;
  logic        e_err;
  bit          inr, ro;

  initial begin
    vecs[0]  = '{0, 2'b01, 3'd2, 32'hDEADBEEF, 6'h00, 6'h04, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1, 2'b01, 3'd2, 32'h000000F0, 6'h00, 6'h04, 32'h000000F0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1, 2'b10, 3'd2, 32'h0000000F, 6'h00, 6'h04, 32'h000000FF, 32'h000000F0, 1'b0};
    vecs[3]  = '{1, 2'b11, 3'd2, 32'h000000C0, 6'h00, 6'h04, 32'h0000003F, 32'h000000FF, 1'b0};
    vecs[4]  = '{0, 2'b00, 3'd2, 32'h0,        6'h00, 6'h00, 32'h0,        32'h0000003F, 1'b0};
    vecs[5]  = '{0, 2'b01, 3'd7, 32'h12345678, 6'h00, 6'h00, 32'h0,        32'h0,        1'b1};
    vecs[6]  = '{1, 2'b00, 3'd6, 32'h0,        6'h00, 6'h00, 32'h0,        32'h0,        1'b1};
    vecs[7]  = '{0, 2'b01, 3'd5, 32'hA5A5A5A5, 6'h00, 6'h20, 32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[8]  = '{0, 2'b10, 3'd5, 32'h0,        6'h00, 6'h20, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
    vecs[9]  = '{1, 2'b00, 3'd5, 32'h0,        6'h20, 6'h00, 32'h0,        32'hA5A5A5A5, 1'b1};
    vecs[10] = '{0, 2'b11, 3'd0, 32'h0,        6'h00, RoEn ? 6'h00 : 6'h01, 32'h0, 32'h0, RoEn};
    vecs[11] = '{1, 2'b01, 3'd0, 32'h11112222, 6'h01, RoEn ? 6'h00 : 6'h01,
                 RoEn ? 32'h0 : 32'h11112222, 32'h0, 1'b1};
    vecs[12] = '{0, 2'b00, 3'd0, 32'h0,        6'h00, 6'h00, 32'h0, RoEn ? 32'h0 : 32'h11112222, 1'b0};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_wen", 32'(csr_wr_en), 32'h0);
    chk("rst_wdata", csr_wr_data, 32'h0);
    #1 rst_n = 1'b1;

    // directed vectors, one access each
    for (int i = 0; i < 13; i++) begin
      v = vecs[i];
      @(posedge clk); #1;
      rd_err = v.rderr;
      set_port(v.id, v.op, v.addr, v.wd);
      req = (v.id == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), 32'(gnt), (v.id == 0) ? 32'h1 : 32'h2);
      chk($sformatf("v%0d_wen_c0", i), 32'(csr_wr_en), 32'h0);
      @(posedge clk); #1;
      req = 2'b00;
      set_port(v.id, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom);
      @(negedge clk);
      chk($sformatf("v%0d_wen", i), 32'(csr_wr_en), 32'(v.e_wen));
      chk($sformatf("v%0d_wdata", i), csr_wr_data, v.e_wd);
      chk($sformatf("v%0d_rvalid_c1", i), 32'(rvalid), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid), (v.id == 0) ? 32'h1 : 32'h2);
      chk($sformatf("v%0d_rdata", i), rdata, v.e_rd);
      chk($sformatf("v%0d_err", i), 32'(err), 32'(v.e_err));
      chk($sformatf("v%0d_wen_c2", i), 32'(csr_wr_en), 32'h0);
    end
    chk("csr2_final", csr_mem[2], 32'h0000003F);

    // reset during the execute cycle of a write
    @(posedge clk); #1;
    rd_err = '0;
    set_port(0, 2'b01, 3'd1, 32'hCAFEF00D);
    req = 2'b01;
    @(negedge clk);
    chk("rx_gnt", 32'(gnt), 32'h1);
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    chk("rx_wen_before", 32'(csr_wr_en), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    chk("rx_wen_async", 32'(csr_wr_en), 32'h0);
    chk("rx_wdata_async", csr_wr_data, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("rx_no_rvalid%0d", c), 32'(rvalid), 32'h0);
    end

    // both requesters hold reads: grants alternate starting from requester 0
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      set_port(0, 2'b00, 3'd0, 32'h0);
      set_port(1, 2'b00, 3'd1, 32'h0);
      req = (c < 12) ? 2'b11 : 2'b00;
      @(negedge clk);
      chk($sformatf("alt_gnt%0d", c), 32'(gnt),
          (c < 12 && c % 3 == 0) ? (((c / 3) % 2 == 0) ? 32'h1 : 32'h2) : 32'h0);
      chk($sformatf("alt_rvalid%0d", c), 32'(rvalid),
          (c % 3 == 2) ? (((c / 3) % 2 == 0) ? 32'h1 : 32'h2) : 32'h0);
    end

    // random traffic against the reference model
    for (int k = 0; k < NumCsr; k++) m_mem[k] = 32'h0;
    free_at = 0; acc_v = 0; last_own = 1'b1;
    h_v[0] = 0; h_v[1] = 0;
    for (int c = 0; c < 700; c++) begin
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        if (c < 600 && !h_v[r] && $urandom_range(0, 2) != 0) begin
          h_v[r]    = 1'b1;
          h_op[r]   = 2'($urandom_range(0, 3));
          h_addr[r] = 3'($urandom_range(0, 7));
          h_wd[r]   = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
        end
        set_port(r, h_op[r], h_addr[r], h_wd[r]);
      end
      req = {h_v[1], h_v[0]};
      rd_err = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'h0;
      @(negedge clk);

      e_gnt = 2'b00; e_rv = 2'b00; e_wen = '0; e_wd = 32'h0; e_rd = 32'h0; e_err = 1'b0;
      if (acc_v && c == acc_g + 1) begin
        inr     = (acc_addr < NumCsr);
        ro      = RoEn && inr && RoMask[acc_addr] && (acc_op != 2'b00);
        acc_rd  = inr ? m_mem[acc_addr] : 32'h0;
        acc_err = !inr || ro || (inr && rd_err[acc_addr]);
        if (inr && !ro && acc_op != 2'b00) begin
          e_wen = 6'(1 << acc_addr);
          e_wd  = apply_op(acc_op, m_mem[acc_addr], acc_wd);
          m_mem[acc_addr] = e_wd;
        end
      end
      if (acc_v && c == acc_g + 2) begin
        e_rv  = acc_own ? 2'b10 : 2'b01;
        e_rd  = acc_rd;
        e_err = acc_err;
        acc_v = 1'b0;
      end
      if (c >= free_at && (h_v[0] || h_v[1])) begin
        w        = (h_v[0] && h_v[1]) ? !last_own : h_v[1];
        e_gnt    = w ? 2'b10 : 2'b01;
        acc_v    = 1'b1; acc_g = c; acc_own = w;
        acc_op   = h_op[w]; acc_addr = h_addr[w]; acc_wd = h_wd[w];
        free_at  = c + 3;
        last_own = w;
        h_v[w]   = 1'b0;
      end
      chk("rnd_gnt", 32'(gnt), 32'(e_gnt));
      chk("rnd_wen", 32'(csr_wr_en), 32'(e_wen));
      chk("rnd_wdata", csr_wr_data, e_wd);
      chk("rnd_rvalid", 32'(rvalid), 32'(e_rv));
      chk("rnd_rdata", rdata, e_rd);
      chk("rnd_err", 32'(err), 32'(e_err));
    end
    chk("rnd_drained", 32'({h_v[1], h_v[0]}), 32'h0);
    for (int k = 0; k < NumCsr; k++) chk($sformatf("rnd_mem%0d", k), csr_mem[k], m_mem[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
